inst_mem_ctrl: RTL and testbench
================================

INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 32, instruction word width.
REQ-002 Parameter RAM_ADDR_BITS, default 10, instruction memory address width.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, end-of-program / halt instruction encoding.
REQ-004 clk  in  1  single clock; all state updates on posedge (memory reads on negedge).
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse: begin program load.
REQ-007 rx_data  in  8  loader byte stream, MSB-first per word.
REQ-008 rx_valid  in  1  rx_data valid.
REQ-009 rx_ready  out  1  controller accepts byte this cycle.
REQ-010 step_mode  in  1  level: 1 = single-step execution, 0 = continuous.
REQ-011 step  in  1  one-cycle pulse: advance one instruction in step mode.
REQ-012 halt_seen  in  1  pipeline decoded HALT_WORD.
REQ-013 fetch_addr  in  RAM_ADDR_BITS  PC-derived word address from fetch stage.
REQ-014 fetch_en  out  1  enables PC update / fetch this cycle.
REQ-015 mem_we  out  1  instruction memory write strobe.
REQ-016 mem_addr  out  RAM_ADDR_BITS  instruction memory address.
REQ-017 mem_wdata  out  RAM_WIDTH  instruction memory write data.
REQ-018 state  out  2  IDLE=00, LOAD=01, RUN=10, HALT=11.
REQ-019 word_count  out  RAM_ADDR_BITS+1  words written in last/current load.

Function
REQ-020 FSM: IDLE -start-> LOAD; LOAD -(HALT_WORD written or memory full)-> RUN; RUN -halt_seen-> HALT; HALT -start-> LOAD; start ignored in LOAD and RUN.
REQ-021 Entering LOAD: byte counter, write address and word_count cleared to 0.
REQ-022 LOAD: rx_ready=1 except during write cycle; byte accepted on posedge with rx_valid&&rx_ready, shifted into word register (word = {word[23:0], rx_data}).
REQ-023 4th accepted byte: next cycle mem_we=1 for exactly one cycle, mem_addr=write address, mem_wdata=assembled word, rx_ready=0; write address and word_count increment at end of that cycle.
REQ-024 If written word equals HALT_WORD: state becomes RUN the cycle after the write; HALT_WORD itself is stored.
REQ-025 Full: write to address 2**RAM_ADDR_BITS-1 forces RUN after the write; address never wraps; word_count saturates at 2**RAM_ADDR_BITS.
REQ-026 Outside LOAD: mem_we=0, rx_ready=0, mem_wdata holds last value; mem_addr=fetch_addr (combinational) in RUN and HALT, write address in LOAD/IDLE.
REQ-027 RUN, step_mode=0: fetch_en=1 every cycle; step_mode=1: fetch_en=step (one cycle per pulse).
REQ-028 halt_seen in RUN: fetch_en=0 same cycle (overrides step); state=HALT next cycle.
REQ-029 IDLE, LOAD, HALT: fetch_en=0.
REQ-030 step_mode changes take effect the same cycle; step pulses outside RUN discarded.
REQ-031 Partial word (1-3 bytes) pending when state leaves LOAD by reset: discarded, not written.

Reset
REQ-032 rst_n low: immediately state=IDLE, rx_ready=0, fetch_en=0, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, byte counter=0; no memory write may occur during or on the edge following reset release.
REQ-033 Reset mid-LOAD abandons the load; memory contents already written are left untouched.

Verification
REQ-034 start, bytes 20,08,00,05 then FF,FF,FF,FF -> two mem_we pulses: addr0=32'h2008_0005, addr1=32'hFFFF_FFFF; state RUN; word_count=2.
REQ-035 RUN, step_mode=0, fetch_addr=0..3 -> fetch_en=1 each cycle, mem_addr follows fetch_addr; halt_seen at cycle 4 -> fetch_en=0 that cycle, state=HALT next.
REQ-036 RUN, step_mode=1, three step pulses over 20 cycles -> exactly three fetch_en cycles, aligned with pulses.
REQ-037 RAM_ADDR_BITS=2, 5 non-halt words sent -> 4 writes (addr 0..3), RUN after 4th, 5th word bytes get rx_ready=0, word_count=4.
REQ-038 rst_n low after 2 bytes of 2nd word -> state IDLE, mem_we never asserted for that word; start again -> write address restarts at 0.
REQ-039 rx_valid held high continuously in LOAD -> one byte per cycle except write cycles (rx_ready=0), no byte lost or duplicated.

Source files
------------

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: assembles a byte stream into words, writes them
// into instruction memory, then hands the memory address to the fetch stage for execution.
module inst_mem_ctrl #(
  parameter int                   RAM_WIDTH     = 32,
  parameter int                   RAM_ADDR_BITS = 10,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD     = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic                     step_mode,
  input  logic                     step,
  input  logic                     halt_seen,
  input  logic [RAM_ADDR_BITS-1:0] fetch_addr,
  output logic                     fetch_en,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  output logic [1:0]               state,
  output logic [RAM_ADDR_BITS:0]   word_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [RAM_ADDR_BITS:0]   CNT_ONE   = {{RAM_ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [RAM_ADDR_BITS:0]   CNT_MAX   = {1'b1, {RAM_ADDR_BITS{1'b0}}};

  state_t                   state_q;
  logic [1:0]               byte_cnt;
  logic [RAM_WIDTH-9:0]     word_p0;
  logic [RAM_WIDTH-1:0]     word_next;
  logic                     vld_p1;
  logic [RAM_WIDTH-1:0]     wdata_p1;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [RAM_ADDR_BITS:0]   wcount;
  logic                     byte_acc;
  logic                     addr_full;

  assign byte_acc   = rx_valid && rx_ready;
  assign word_next  = {word_p0, rx_data};
  assign addr_full  = &wr_addr;

  assign rx_ready   = (state_q == LOAD) && !vld_p1;
  assign mem_we     = vld_p1;
  assign mem_wdata  = wdata_p1;
  assign mem_addr   = (state_q == RUN || state_q == HALT) ? fetch_addr : wr_addr;
  assign fetch_en   = (state_q == RUN) && !halt_seen && (!step_mode || step);
  assign state      = state_q;
  assign word_count = wcount;

  // Stage p0: byte assembly, holds the leading bytes of the word in flight
  always_ff @(posedge clk) begin
    if (byte_acc) word_p0 <= word_next[RAM_WIDTH-9:0];
  end

  // Stage p1: completed word waits one cycle as the memory write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      byte_cnt <= 2'd0;
      vld_p1   <= 1'b0;
      wdata_p1 <= '0;
      wr_addr  <= '0;
      wcount   <= '0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            state_q  <= LOAD;
            byte_cnt <= 2'd0;
            wr_addr  <= '0;
            wcount   <= '0;
          end
        end
        LOAD: begin
          if (vld_p1) begin
            vld_p1 <= 1'b0;
            if (wdata_p1 == HALT_WORD || addr_full) state_q <= RUN;
            // The top address is terminal: no wrap, count pins at capacity
            if (!addr_full) wr_addr <= wr_addr + ADDR_ONE;
            if (wcount != CNT_MAX) wcount <= wcount + CNT_ONE;
          end else if (byte_acc) begin
            if (byte_cnt == 2'd3) begin
              vld_p1   <= 1'b1;
              wdata_p1 <= word_next;
              byte_cnt <= 2'd0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        RUN: begin
          if (halt_seen) state_q <= HALT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: a default-size and a 4-word instance share one stimulus
// stream and are checked every cycle against a behavioural model plus literal expectations.
module tb_inst_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        halt_seen = 1'b0;
  logic [9:0]  fetch_addr = 10'd0;

  logic        rdy0, fe0, we0;
  logic [9:0]  addr0;
  logic [31:0] wd0;
  logic [1:0]  st0;
  logic [10:0] wc0;

  logic        rdy1, fe1, we1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  logic [1:0]  st1;
  logic [2:0]  wc1;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] log0[$];
  logic [63:0] log1[$];

  always #5 clk = ~clk;

  inst_mem_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .step_mode(step_mode), .step(step), .halt_seen(halt_seen),
    .fetch_addr(fetch_addr), .fetch_en(fe0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wd0), .state(st0), .word_count(wc0)
  );

  inst_mem_ctrl #(.RAM_ADDR_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .step_mode(step_mode), .step(step), .halt_seen(halt_seen),
    .fetch_addr(fetch_addr[1:0]), .fetch_en(fe1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wd1), .state(st1), .word_count(wc1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=IDLE 1=LOAD 2=RUN 3=HALT, one entry per instance
  int          m_st[2];
  int          m_nb[2];
  int          m_waddr[2];
  int          m_wcnt[2];
  bit          m_wpend[2];
  logic [31:0] m_acc[2];
  logic [31:0] m_wdata[2];

  function automatic int cap(input int i);
    return (i == 0) ? 1024 : 4;
  endfunction

  task automatic m_reset(input int i);
    m_st[i] = 0; m_nb[i] = 0; m_waddr[i] = 0; m_wcnt[i] = 0;
    m_wpend[i] = 1'b0; m_wdata[i] = 32'h0;
  endtask

  task automatic m_advance(input int i);
    case (m_st[i])
      0, 3: if (start) begin
        m_st[i] = 1; m_nb[i] = 0; m_waddr[i] = 0; m_wcnt[i] = 0; m_wpend[i] = 1'b0;
      end
      1: begin
        if (m_wpend[i]) begin
          m_wpend[i] = 1'b0;
          if (m_wdata[i] == 32'hFFFF_FFFF || m_waddr[i] == cap(i) - 1) m_st[i] = 2;
          if (m_waddr[i] < cap(i) - 1) m_waddr[i]++;
          if (m_wcnt[i] < cap(i)) m_wcnt[i]++;
        end else if (rx_valid) begin
          m_acc[i] = (m_acc[i] << 8) | {24'h0, rx_data};
          m_nb[i]++;
          if (m_nb[i] == 4) begin
            m_wdata[i] = m_acc[i];
            m_wpend[i] = 1'b1;
            m_nb[i] = 0;
          end
        end
      end
      2: if (halt_seen) m_st[i] = 3;
      default: ;
    endcase
  endtask

  task automatic m_compare(input int i);
    logic [63:0] a_st, a_rdy, a_fe, a_we, a_addr, a_wd, a_wc;
    int e_addr;
    bit e_fe;
    a_st   = (i == 0) ? 64'(st0)   : 64'(st1);
    a_rdy  = (i == 0) ? 64'(rdy0)  : 64'(rdy1);
    a_fe   = (i == 0) ? 64'(fe0)   : 64'(fe1);
    a_we   = (i == 0) ? 64'(we0)   : 64'(we1);
    a_addr = (i == 0) ? 64'(addr0) : 64'(addr1);
    a_wd   = (i == 0) ? 64'(wd0)   : 64'(wd1);
    a_wc   = (i == 0) ? 64'(wc0)   : 64'(wc1);
    e_addr = (m_st[i] >= 2) ? (int'(fetch_addr) % cap(i)) : m_waddr[i];
    e_fe   = (m_st[i] == 2) && !halt_seen && (!step_mode || step);
    chk($sformatf("u%0d.state", i),      a_st,   64'(m_st[i]));
    chk($sformatf("u%0d.rx_ready", i),   a_rdy,  64'((m_st[i] == 1) && !m_wpend[i]));
    chk($sformatf("u%0d.fetch_en", i),   a_fe,   64'(e_fe));
    chk($sformatf("u%0d.mem_we", i),     a_we,   64'(m_wpend[i]));
    chk($sformatf("u%0d.mem_addr", i),   a_addr, 64'(e_addr));
    chk($sformatf("u%0d.mem_wdata", i),  a_wd,   64'(m_wdata[i]));
    chk($sformatf("u%0d.word_count", i), a_wc,   64'(m_wcnt[i]));
  endtask

  initial begin
    m_reset(0);
    m_reset(1);
    m_acc[0] = 32'h0;
    m_acc[1] = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_reset(0);
        m_reset(1);
      end
      m_compare(0);
      m_compare(1);
      if (we0) log0.push_back({32'(addr0), wd0});
      if (we1) log1.push_back({32'(addr1), wd1});
      @(posedge clk);
      if (rst_n) begin
        m_advance(0);
        m_advance(1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Holds rx_valid high and waits for the default instance to take the byte
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_byte: byte %0h not accepted within 20 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nfe;
    // Reset, then a step pulse while idle must not fetch
    tick(3);
    @(negedge clk);
    chk("rst.state", 64'(st0), 64'd0);
    chk("rst.word_count", 64'(wc0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);

    // Two-word program ending in the halt word, rx_valid held high throughout
    log0.delete();
    log1.delete();
    pulse_start();
    send_word(32'h2008_0005);
    send_word(32'hFFFF_FFFF);
    rx_valid = 1'b0;
    tick(3);
    chk("load.nwrites0", 64'(log0.size()), 64'd2);
    chk("load.nwrites1", 64'(log1.size()), 64'd2);
    if (log0.size() >= 2) begin
      chk("load.w0", log0[0], 64'h0000_0000_2008_0005);
      chk("load.w1", log0[1], 64'h0000_0001_FFFF_FFFF);
    end
    chk("load.state", 64'(st0), 64'd2);
    chk("load.word_count", 64'(wc0), 64'd2);

    // Single-step: three pulses in 20 cycles, plus an ignored start in RUN
    step_mode = 1'b1;
    nfe = 0;
    for (int c = 0; c < 20; c++) begin
      step  = (c == 3 || c == 9 || c == 15);
      start = (c == 5);
      @(negedge clk);
      if (fe0) nfe++;
      @(posedge clk);
      #1;
    end
    step  = 1'b0;
    start = 1'b0;
    chk("step.nfetch", 64'(nfe), 64'd3);
    chk("step.state", 64'(st0), 64'd2);

    // Continuous run over four addresses, then halt
    step_mode = 1'b0;
    for (int a = 0; a < 4; a++) begin
      fetch_addr = 10'(a);
      @(negedge clk);
      chk("run.fetch_en", 64'(fe0), 64'd1);
      chk("run.mem_addr", 64'(addr0), 64'(a));
      @(posedge clk);
      #1;
    end
    fetch_addr = 10'd4;
    halt_seen  = 1'b1;
    @(negedge clk);
    chk("halt.fetch_en", 64'(fe0), 64'd0);
    @(posedge clk);
    #1;
    halt_seen = 1'b0;
    @(negedge clk);
    chk("halt.state", 64'(st0), 64'd3);
    @(posedge clk);
    #1;

    // Reset in the middle of a word drops it; the next load restarts at address 0
    log0.delete();
    log1.delete();
    pulse_start();
    send_word(32'h1122_3344);
    send_byte(8'h55);
    send_byte(8'h66);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    tick(2);
    @(negedge clk);
    chk("abort.state", 64'(st0), 64'd0);
    chk("abort.nwrites", 64'(log0.size()), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    send_word(32'hAABB_CCDD);
    send_word(32'hFFFF_FFFF);
    rx_valid = 1'b0;
    tick(3);
    chk("reload.nwrites", 64'(log0.size()), 64'd3);
    if (log0.size() >= 3) begin
      chk("reload.w0", log0[1], 64'h0000_0000_AABB_CCDD);
      chk("reload.w1", log0[2], 64'h0000_0001_FFFF_FFFF);
    end

    // Five plain words into the 4-word instance: fills, enters RUN, refuses the fifth
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    log0.delete();
    log1.delete();
    pulse_start();
    for (int k = 0; k < 5; k++) send_word(32'h0102_0300 + 32'(k));
    rx_valid = 1'b0;
    tick(3);
    chk("full.nwrites1", 64'(log1.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (log1.size() > k) chk($sformatf("full.w%0d", k), log1[k], {32'(k), 32'h0102_0300 + 32'(k)});
    end
    chk("full.state1", 64'(st1), 64'd2);
    chk("full.word_count1", 64'(wc1), 64'd4);
    chk("full.state0", 64'(st0), 64'd1);
    chk("full.word_count0", 64'(wc0), 64'd5);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
